// File: rtl/scs8hd_orsync_stretch.sv
// OR3B-style request merge (A | B | ~CN), synchronized into CLK, edge-detected and
// served as a registered request X with a minimum width, acknowledge hold-off and one pending slot.
module scs8hd_orsync_stretch #(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 4,
    parameter int CNT_W       = 4
) (
    input  logic       CLK,
    input  logic       RESETB,
    input  logic       A,
    input  logic       B,
    input  logic       CN,
    input  logic       ACK,
    output logic       X,
    output logic       BUSY,
    output logic       OVF,
    output logic [1:0] STATE_DBG
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSERT   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH - 1);

    logic                   m;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic                   rise;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pending_q, pending_d;
    logic                   ack_seen_q, ack_seen_d;
    logic                   ovf_q, ovf_d;
    logic                   x_q, x_d;
    logic                   busy_q, busy_d;
    logic                   pend_now;

    assign m = A | B | ~CN;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], m};
            s_d_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~s_d_q;

    // State register; X and BUSY are registered copies of next-state decodes.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            ack_seen_q <= 1'b0;
            ovf_q      <= 1'b0;
            x_q        <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            ack_seen_q <= ack_seen_d;
            ovf_q      <= ovf_d;
            x_q        <= x_d;
            busy_q     <= busy_d;
        end
    end

    // A rise arriving on the very edge ASSERT/WAIT_ACK exits still routes through GAP,
    // otherwise it would be latched as pending while the FSM sits in IDLE.
    assign pend_now = pending_q | rise;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        ack_seen_d = ack_seen_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_ASSERT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_ASSERT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (ACK) begin
                        ack_seen_d = 1'b1;
                    end
                end else if (ack_seen_q | ACK) begin
                    state_d    = pend_now ? ST_GAP : ST_IDLE;
                    ack_seen_d = 1'b0;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ACK) begin
                    state_d    = pend_now ? ST_GAP : ST_IDLE;
                    ack_seen_d = 1'b0;
                end
            end
            ST_GAP: begin
                state_d   = ST_ASSERT;
                cnt_d     = CNT_LOAD;
                pending_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rise && (state_q != ST_IDLE)) begin
            if (pending_q) begin
                ovf_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_comb begin
        x_d    = (state_d == ST_ASSERT) || (state_d == ST_WAIT_ACK);
        busy_d = (state_d != ST_IDLE) || pending_d;
    end

    assign X         = x_q;
    assign BUSY      = busy_q;
    assign OVF       = ovf_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_scs8hd_orsync_stretch.sv
// Bench for scs8hd_orsync_stretch: four parameterizations share one stimulus stream and are
// compared each cycle against an event-level service model through an expected queue.
module tb_scs8hd_orsync_stretch;

    localparam int NI = 4;
    localparam int W  = 4 * NI;

    logic            clk = 1'b0;
    logic            rstn;
    logic            a, b, cn, ack;
    logic [NI-1:0]   x_v, busy_v, ovf_v;
    logic [2*NI-1:0] st_v;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Instance parameters: sync depth and minimum X width.
    int stg[NI] = '{2, 2, 4, 2};
    int str[NI] = '{4, 15, 4, 1};

    // Service model state per instance.
    bit serving[NI];
    bit in_gap[NI];
    bit pending[NI];
    bit ovf[NI];
    bit acked[NI];
    int served[NI];
    bit mh[NI][6];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    scs8hd_orsync_stretch #(.SYNC_STAGES(2), .STRETCH(4), .CNT_W(4)) u0 (
        .CLK(clk), .RESETB(rstn), .A(a), .B(b), .CN(cn), .ACK(ack),
        .X(x_v[0]), .BUSY(busy_v[0]), .OVF(ovf_v[0]), .STATE_DBG(st_v[1:0]));
    scs8hd_orsync_stretch #(.SYNC_STAGES(2), .STRETCH(15), .CNT_W(4)) u1 (
        .CLK(clk), .RESETB(rstn), .A(a), .B(b), .CN(cn), .ACK(ack),
        .X(x_v[1]), .BUSY(busy_v[1]), .OVF(ovf_v[1]), .STATE_DBG(st_v[3:2]));
    scs8hd_orsync_stretch #(.SYNC_STAGES(4), .STRETCH(4), .CNT_W(4)) u2 (
        .CLK(clk), .RESETB(rstn), .A(a), .B(b), .CN(cn), .ACK(ack),
        .X(x_v[2]), .BUSY(busy_v[2]), .OVF(ovf_v[2]), .STATE_DBG(st_v[5:4]));
    scs8hd_orsync_stretch #(.SYNC_STAGES(2), .STRETCH(1), .CNT_W(4)) u3 (
        .CLK(clk), .RESETB(rstn), .A(a), .B(b), .CN(cn), .ACK(ack),
        .X(x_v[3]), .BUSY(busy_v[3]), .OVF(ovf_v[3]), .STATE_DBG(st_v[7:6]));

    // Per instance nibble: {idle, OVF, BUSY, X}.
    function automatic logic [W-1:0] dut_vec();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NI; i++) begin
            v[4*i+:4] = {(st_v[2*i+:2] == 2'd0), ovf_v[i], busy_v[i], x_v[i]};
        end
        return v;
    endfunction

    task automatic cmp(input string tag, input logic [W-1:0] exp);
        logic [W-1:0] got;
        string fn[4];
        fn = '{"X", "BUSY", "OVF", "IDLE"};
        got = dut_vec();
        for (int i = 0; i < NI; i++) begin
            for (int f = 0; f < 4; f++) begin
                checks++;
                if (got[4*i+f] !== exp[4*i+f]) begin
                    errors++;
                    $display("FAIL %s inst%0d %s got=%0b exp=%0b t=%0t",
                             tag, i, fn[f], got[4*i+f], exp[4*i+f], $time);
                end
            end
        end
    endtask

    // ---------------- reference model ----------------
    // One call per upcoming clock edge, given the inputs held across that edge.
    task automatic model_edge(input bit m, input bit ack_i, input bit rst_i);
        logic [W-1:0] e;
        bit r, active, nserv, ngap, npend, busy;
        e = '0;
        for (int i = 0; i < NI; i++) begin
            if (!rst_i) begin
                serving[i] = 0; in_gap[i] = 0; pending[i] = 0; ovf[i] = 0;
                acked[i] = 0; served[i] = 0;
                for (int j = 0; j < 6; j++) mh[i][j] = 0;
            end else begin
                r      = mh[i][stg[i]-1] & ~mh[i][stg[i]];
                active = serving[i] | in_gap[i];
                nserv  = serving[i];
                ngap   = in_gap[i];
                npend  = pending[i];
                if (serving[i]) begin
                    if ((served[i] + 1 >= str[i]) && (acked[i] | ack_i)) begin
                        nserv = 0;
                        ngap  = pending[i] | r;
                        served[i] = 0;
                        acked[i]  = 0;
                    end else begin
                        served[i]++;
                        acked[i] = acked[i] | ack_i;
                    end
                end else if (in_gap[i]) begin
                    ngap = 0; nserv = 1; npend = 0;
                    served[i] = 0; acked[i] = 0;
                end else if (r) begin
                    nserv = 1; served[i] = 0; acked[i] = 0;
                end
                if (r && active) begin
                    if (pending[i]) ovf[i] = 1;
                    else npend = 1;
                end
                serving[i] = nserv;
                in_gap[i]  = ngap;
                pending[i] = npend;
                for (int j = 5; j > 0; j--) mh[i][j] = mh[i][j-1];
                mh[i][0] = m;
            end
            busy = serving[i] | in_gap[i] | pending[i];
            e[4*i+:4] = {~busy & ~pending[i], ovf[i], busy, serving[i]};
        end
        exp_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    // Called at posedge+2: applies inputs for the next edge and queues its expected outcome.
    task automatic step(input bit a_i, input bit b_i, input bit cn_i, input bit ack_i,
                        input bit rst_i);
        bit was_up;
        logic [W-1:0] rst_vec;
        was_up = rstn;
        a = a_i; b = b_i; cn = cn_i; ack = ack_i; rstn = rst_i;
        if (was_up && !rst_i) begin
            #1;
            rst_vec = '0;
            for (int i = 0; i < NI; i++) rst_vec[4*i+3] = 1'b1;
            cmp("async_reset", rst_vec);
        end
        model_edge(a_i | b_i | ~cn_i, ack_i, rst_i);
        @(posedge clk);
        #2;
    endtask

    task automatic rep(input int n, input bit a_i, input bit b_i, input bit cn_i,
                       input bit ack_i, input bit rst_i);
        for (int k = 0; k < n; k++) step(a_i, b_i, cn_i, ack_i, rst_i);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                cmp("cycle", exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        a = 0; b = 0; cn = 1; ack = 0; rstn = 0;
        repeat (2) @(posedge clk);
        #2;
        rep(3, 0, 0, 1, 0, 0);

        // quiet inputs
        for (int k = 0; k < 20; k++) step(0, 0, 1, 1'($urandom_range(0, 1)), 1);

        // CN falls and stays low, ACK tied high: one event only
        rep(14, 0, 0, 0, 1, 1);
        rep(20, 0, 0, 1, 1, 1);

        // A pulse, ACK held off well past the minimum width
        rep(3, 1, 0, 1, 0, 1);
        rep(15, 0, 0, 1, 0, 1);
        rep(1, 0, 0, 1, 1, 1);
        rep(25, 0, 0, 1, 0, 1);

        // second B rise during ASSERT -> GAP then second assertion
        rep(1, 0, 1, 1, 1, 1);
        rep(2, 0, 0, 1, 1, 1);
        rep(1, 0, 1, 1, 1, 1);
        rep(25, 0, 0, 1, 1, 1);

        // three rises inside one long ASSERT -> overflow
        rep(1, 1, 0, 1, 1, 1);
        rep(3, 0, 0, 1, 1, 1);
        rep(1, 0, 1, 1, 1, 1);
        rep(3, 0, 0, 1, 1, 1);
        rep(1, 0, 0, 0, 1, 1);
        rep(40, 0, 0, 1, 1, 1);

        // reset mid-ASSERT with A held high, then release
        rep(4, 1, 0, 1, 0, 1);
        rep(3, 1, 0, 1, 0, 0);
        rep(12, 1, 0, 1, 1, 1);
        rep(25, 0, 0, 1, 1, 1);

        // randomized segments
        for (int s = 0; s < 80; s++) begin
            bit ra, rb, rcn;
            int len;
            len = $urandom_range(1, 8);
            ra  = ($urandom_range(0, 3) == 0);
            rb  = ($urandom_range(0, 3) == 0);
            rcn = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < len; k++) begin
                step(ra, rb, rcn, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) != 0));
            end
        end
        rep(20, 0, 0, 1, 1, 1);

        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
